// File: rtl/dekatron_counter_chain_if.sv
// Command/status bundle of the dekatron counter chain: request strobe, load value, digit outputs and guide pulses.
// The master drives commands; the slave, which is the counter, returns the state and the tube guide lines.
interface dekatron_counter_chain_if #(
  parameter int DIGITS = 4
);
  logic                   Request;
  logic                   Dec;
  logic                   Set;
  logic [DIGITS*10-1:0]   In;
  logic [DIGITS*10-1:0]   Out;
  logic                   Ready;
  logic                   Zero;
  logic                   Carry;
  logic                   Err;
  logic [DIGITS-1:0]      PulseRight_n;
  logic [DIGITS-1:0]      PulseLeft_n;

  modport master (
    output Request, Dec, Set, In,
    input  Out, Ready, Zero, Carry, Err, PulseRight_n, PulseLeft_n
  );

  modport slave (
    input  Request, Dec, Set, In,
    output Out, Ready, Zero, Carry, Err, PulseRight_n, PulseLeft_n
  );
endinterface

// File: rtl/dekatron_counter_chain.sv
// One-hot multi-digit counter with two-phase guide pulses and ripple carry; 3 cycles per touched digit, load takes 1 cycle.
// Ready is low while busy, and a Request that arrives then is dropped, not queued.
module dekatron_counter_chain #(
  parameter int DIGITS = 4,
  parameter int RADIX  = 10
) (
  input logic                 Clk,
  input logic                 Rst,
  dekatron_counter_chain_if.slave bus
);
  localparam int          DW         = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [9:0]  DIGIT_MASK = 10'((1 << RADIX) - 1);

  typedef enum logic [2:0] {IDLE, PULSE_A, PULSE_B, SETTLE, LOAD} state_t;

  state_t               state, state_nxt;
  logic [DW-1:0]        d, d_nxt;
  logic                 dec_q, wrap_q, carry_q, err_q;
  logic [DIGITS*10-1:0] out_q, load_val;
  logic                 load_bad;
  logic [9:0]           cur_dig, step_dig;
  logic                 step_wrap, last_dig;
  logic [DIGITS-1:0]    right_n, left_n;

  assign last_dig = (d == DW'(DIGITS - 1));

  // Rotate the selected digit one place within RADIX in the latched direction.
  always_comb begin
    cur_dig  = 10'b0;
    step_dig = 10'b0;
    for (int g = 0; g < DIGITS; g++)
      if (d == DW'(g)) cur_dig = out_q[g*10 +: 10];
    for (int i = 0; i < RADIX; i++) begin
      if (dec_q) step_dig[(i + RADIX - 1) % RADIX] = cur_dig[i];
      else       step_dig[(i + 1) % RADIX]         = cur_dig[i];
    end
    step_wrap = dec_q ? cur_dig[0] : cur_dig[RADIX-1];
  end

  // Malformed or out-of-radix fields fall back to value 0.
  always_comb begin
    load_val = '0;
    load_bad = 1'b0;
    for (int g = 0; g < DIGITS; g++) begin
      if ($onehot(bus.In[g*10 +: 10]) && ((bus.In[g*10 +: 10] & ~DIGIT_MASK) == 10'b0)) begin
        load_val[g*10 +: 10] = bus.In[g*10 +: 10];
      end else begin
        load_val[g*10 +: 10] = 10'b0000000001;
        load_bad             = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    d_nxt     = d;
    right_n   = '1;
    left_n    = '1;
    case (state)
      IDLE: begin
        if (bus.Request) begin
          if (bus.Set) begin
            state_nxt = LOAD;
          end else begin
            d_nxt     = '0;
            state_nxt = PULSE_A;
          end
        end
      end
      PULSE_A: begin
        for (int g = 0; g < DIGITS; g++)
          if (d == DW'(g)) begin
            if (dec_q) left_n[g]  = 1'b0;
            else       right_n[g] = 1'b0;
          end
        state_nxt = PULSE_B;
      end
      PULSE_B: begin
        for (int g = 0; g < DIGITS; g++)
          if (d == DW'(g)) begin
            if (dec_q) right_n[g] = 1'b0;
            else       left_n[g]  = 1'b0;
          end
        state_nxt = SETTLE;
      end
      SETTLE: begin
        if (wrap_q && !last_dig) begin
          d_nxt     = d + 1'b1;
          state_nxt = PULSE_A;
        end else begin
          state_nxt = IDLE;
        end
      end
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= IDLE;
      d       <= '0;
      dec_q   <= 1'b0;
      wrap_q  <= 1'b0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      out_q   <= {DIGITS{10'b0000000001}};
    end else begin
      state   <= state_nxt;
      d       <= d_nxt;
      if (state == IDLE && bus.Request) dec_q <= bus.Dec;
      if (state == PULSE_B) begin
        wrap_q <= step_wrap;
        for (int g = 0; g < DIGITS; g++)
          if (d == DW'(g)) out_q[g*10 +: 10] <= step_dig;
      end
      if (state == LOAD) out_q <= load_val;
      // Both flags land on the first Ready cycle and self-clear after it.
      carry_q <= (state == SETTLE) && wrap_q && last_dig;
      err_q   <= (state == LOAD) && load_bad;
    end
  end

  assign bus.Out          = out_q;
  assign bus.Ready        = (state == IDLE);
  assign bus.Zero         = (out_q == {DIGITS{10'b0000000001}});
  assign bus.Carry        = carry_q;
  assign bus.Err          = err_q;
  assign bus.PulseRight_n = right_n;
  assign bus.PulseLeft_n  = left_n;
endmodule

// File: doc/dekatron_counter_chain.md
# dekatron_counter_chain

Multi-digit, parametrised-radix counter built from cold-cathode-style one-hot digits. Each digit step is a two-phase guide-pulse sequence, with ripple carry/borrow between digits and a parallel load. It supersedes single-tube stepping for the IP/AP/data registers and drives the per-digit guide pulse lines for the physical tubes. The same block covers RADIX=10 (dekatron) and RADIX=8 (octal) registers.

## Interface
Parameters:
- DIGITS, 4, number of cascaded digits; digit 0 is least significant.
- RADIX, 10, states per digit (2..10); digit field is always 10 bits wide, and bits RADIX..9 are always 0.

Ports:
- Clk  in  1  sole clock, rising edge.
- Rst  in  1  reset, synchronous, active-high.
- Request  in  1  command strobe; sampled only when Ready=1.
- Dec  in  1  sampled with Request: 0 = increment, 1 = decrement.
- Set  in  1  sampled with Request: 1 = parallel load from In; Set overrides Dec.
- In  in  DIGITS*10  load value, one-hot per 10-bit digit field.
- Out  out  DIGITS*10  current value, one-hot per digit.
- Ready  out  1  idle, able to accept a command.
- Zero  out  1  all digits hold value 0 (combinational from Out).
- Carry  out  1  one-cycle pulse: the whole chain wrapped (increment past max or decrement past 0).
- Err  out  1  one-cycle pulse: the last load contained an invalid digit.
- PulseRight_n  out  DIGITS  per-digit right guide pulse, active low.
- PulseLeft_n  out  DIGITS  per-digit left guide pulse, active low.

## Operation
- States: IDLE, PULSE_A, PULSE_B, SETTLE, LOAD. A digit index register d ranges 0..DIGITS-1.
- Reset values:
  - every Out digit = 10'b0000000001 (value 0);
  - Ready=1, Zero=1, Carry=0, Err=0;
  - all PulseRight_n/PulseLeft_n=1;
  - state IDLE, d=0.
- IDLE with Request=1:
  - latch Dec and Set.
  - If Set=1, go to LOAD.
  - Otherwise set d=0 and go to PULSE_A.
  - Request in any other state is ignored; it is not queued.
- PULSE_A asserts the first guide on digit d for one cycle: PulseRight_n[d] for increment, PulseLeft_n[d] for decrement.
- PULSE_B asserts the other guide on digit d for one cycle.
- Guide rules:
  - Only digit d is pulsed.
  - Right and Left are never low together on any digit.
  - No pulse is issued in IDLE, SETTLE or LOAD.
- Digit update: on the edge leaving PULSE_B, digit d rotates by one within RADIX.
  - Increment: RADIX-1 wraps to 0.
  - Decrement: 0 wraps to RADIX-1.
- SETTLE:
  - No wrap on digit d: go to IDLE.
  - Wrap and d<DIGITS-1: d=d+1, go to PULSE_A.
  - Wrap and d=DIGITS-1: go to IDLE and set Carry for the first IDLE cycle.
- LOAD, one cycle, no pulses. Each digit field is loaded from In.
  - A digit field that is not exactly one-hot, or whose set bit index is >= RADIX, is loaded as value 0.
  - Any such field raises Err for the first IDLE cycle.
- Rst asserted in any state: all registers take their reset values on that edge and the operation in flight is abandoned.

## Timing
- Command accepted at edge E0 means Ready=0 from cycle 1.
- For an increment/decrement touching k digits (k = 1 + number of ripple carries):
  - digit j is in PULSE_A during cycle 3j+1, PULSE_B during 3j+2, SETTLE during 3j+3;
  - Out of digit j changes at the start of cycle 3j+3;
  - Ready=1 from cycle 3k+1, so latency is 3k cycles.
- Load: LOAD during cycle 1; Out and Err valid and Ready=1 from cycle 2.
- Carry and Err are high for exactly one cycle, coinciding with the first Ready=1 cycle. Otherwise they are 0.
- A new Request in the first Ready cycle is accepted (back-to-back commands are allowed).

## Test plan
- Reset, then increment (DIGITS=4, RADIX=10):
  - Out=0000 -> 0001.
  - PulseRight_n[0] low in cycle 1 only, PulseLeft_n[0] low in cycle 2 only.
  - Ready=1 at cycle 4, Zero 1->0.
- Ripple: load 0999, increment -> 1000.
  - Digits 0,1,2,3 pulsed in order.
  - Ready returns at cycle 13, Carry=0.
- Chain wrap:
  - 9999 +1 -> 0000, latency 12, Carry=1 for one cycle, Zero=1.
  - 0000 decrement -> 9999, with Left-then-Right pulse order and Carry=1.
- RADIX=8: digit 0 at 7, increment -> 0 with carry into digit 1; 0 decrement -> 7.
- Load with In digit 2 = 10'b0000000110 (not one-hot) and, for RADIX=8, digit 1 = value 9:
  - both digits load as 0, other digits load exactly, Err=1 for one cycle, no guide pulses.
- Robustness:
  - Request held during a busy operation is ignored.
  - Rst asserted in PULSE_B of digit 1 during a 0999 ripple gives all-zero Out, Ready=1 and all pulses high on the next cycle.
